// File: rtl/win_scanner_if.sv
// Handshake and result bundle between the game controller and the win scanner.
// Width of grid and win_idx follow the board side N.
interface win_scanner_if #(
  parameter int N = 3
);
  localparam int IDX_W = $clog2(N*N);

  logic                 start;
  logic [2*N*N-1:0]     grid;
  logic                 busy;
  logic                 done;
  logic [1:0]           winner;
  logic                 end_signal;
  logic [IDX_W-1:0]     win_idx;
  logic [1:0]           win_dir;

  modport master (
    output start, grid,
    input  busy, done, winner, end_signal, win_idx, win_dir
  );

  modport slave (
    input  start, grid,
    output busy, done, winner, end_signal, win_idx, win_dir
  );
endinterface

// File: rtl/win_scanner.sv
// Sequential K-in-a-row detector: snapshots the board on start, checks one
// anchor cell per clock in all four directions and commits after N*N cycles.
module win_scanner #(
  parameter  int N     = 3,
  parameter  int K     = 3,
  localparam int IDX_W = $clog2(N*N)
) (
  input  logic clk,
  input  logic resetn,
  win_scanner_if.slave bus
);
  localparam int CELLS = N*N;
  localparam int RC_W  = $clog2(N);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state;
  logic [2*CELLS-1:0]  snap;
  logic [IDX_W-1:0]    idx;
  logic [RC_W-1:0]     row, col;
  logic                p1_found, p2_found, any_empty;
  logic [IDX_W-1:0]    p1_idx, p2_idx;
  logic [1:0]          p1_dir, p2_dir;
  logic                busy_q, done_q, end_q;
  logic [1:0]          winner_q, dir_q;
  logic [IDX_W-1:0]    idx_q;

  logic [3:0]          hit1, hit2;
  logic                cell_empty;
  logic                fin1, fin2, fin_empty;
  logic [IDX_W-1:0]    fin1_idx, fin2_idx;
  logic [1:0]          fin1_dir, fin2_dir;

  // Off-board coordinates read as empty so they can never complete a line.
  function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b,
                                         input int r, input int c);
    logic [1:0] v;
    v = 2'd0;
    if (r >= 0 && r < N && c >= 0 && c < N) v = b[2*(r*N+c) +: 2];
    return v;
  endfunction

  function automatic logic [1:0] first_dir(input logic [3:0] h);
    if (h[0]) return 2'd0;
    if (h[1]) return 2'd1;
    if (h[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_comb begin
    int r, c, dr, dc;
    logic valid;
    logic [1:0] v;
    hit1  = '0;
    hit2  = '0;
    valid = 1'b0;
    v     = 2'd0;
    r     = int'(row);
    c     = int'(col);
    for (int d = 0; d < 4; d++) begin
      dr = (d == 0) ? 0 : 1;
      dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      case (d)
        0:       valid = (c <= N-K);
        1:       valid = (r <= N-K);
        2:       valid = (r <= N-K) && (c <= N-K);
        default: valid = (r <= N-K) && (c >= K-1);
      endcase
      hit1[d] = valid;
      hit2[d] = valid;
      for (int j = 0; j < K; j++) begin
        v = cell_at(snap, r + j*dr, c + j*dc);
        if (v != 2'd1) hit1[d] = 1'b0;
        if (v != 2'd2) hit2[d] = 1'b0;
      end
    end
    v          = cell_at(snap, r, c);
    cell_empty = (v == 2'd0) || (v == 2'd3);
  end

  // Merge this cycle's findings so the final anchor counts toward the commit.
  always_comb begin
    fin1      = p1_found | (|hit1);
    fin2      = p2_found | (|hit2);
    fin_empty = any_empty | cell_empty;
    fin1_idx  = p1_found ? p1_idx : idx;
    fin1_dir  = p1_found ? p1_dir : first_dir(hit1);
    fin2_idx  = p2_found ? p2_idx : idx;
    fin2_dir  = p2_found ? p2_dir : first_dir(hit2);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      snap      <= '0;
      idx       <= '0;
      row       <= '0;
      col       <= '0;
      p1_found  <= 1'b0;
      p2_found  <= 1'b0;
      any_empty <= 1'b0;
      p1_idx    <= '0;
      p2_idx    <= '0;
      p1_dir    <= 2'd0;
      p2_dir    <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      winner_q  <= 2'b00;
      end_q     <= 1'b0;
      idx_q     <= '0;
      dir_q     <= 2'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            snap      <= bus.grid;
            idx       <= '0;
            row       <= '0;
            col       <= '0;
            p1_found  <= 1'b0;
            p2_found  <= 1'b0;
            any_empty <= 1'b0;
            p1_idx    <= '0;
            p2_idx    <= '0;
            p1_dir    <= 2'd0;
            p2_dir    <= 2'd0;
            busy_q    <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          p1_found  <= fin1;
          p2_found  <= fin2;
          any_empty <= fin_empty;
          p1_idx    <= fin1_idx;
          p1_dir    <= fin1_dir;
          p2_idx    <= fin2_idx;
          p2_dir    <= fin2_dir;
          if (idx == IDX_W'(CELLS-1)) begin
            if (fin1) begin
              winner_q <= 2'b01;
              idx_q    <= fin1_idx;
              dir_q    <= fin1_dir;
            end else if (fin2) begin
              winner_q <= 2'b10;
              idx_q    <= fin2_idx;
              dir_q    <= fin2_dir;
            end else begin
              winner_q <= fin_empty ? 2'b00 : 2'b11;
              idx_q    <= '0;
              dir_q    <= 2'd0;
            end
            end_q  <= fin1 | fin2 | ~fin_empty;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            idx <= idx + 1'b1;
            if (col == RC_W'(N-1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.winner     = winner_q;
  assign bus.end_signal = end_q;
  assign bus.win_idx    = idx_q;
  assign bus.win_dir    = dir_q;
endmodule

// File: doc/win_scanner.md
# win_scanner

Parametrised, sequential win detector for an N×N board with K-in-a-row rules. On a `start` pulse it snapshots the flattened board, scans one anchor cell per clock, and reports winner, game-end, draw and the location of the winning line. It sits between the board-state register and the game-control FSM, replacing the fixed 3×3 combinational checker and supporting larger boards without a combinational explosion.

## Interface
- `N`, 3, board side length, 3..8.
- `K`, 3, run length needed to win, 2..N.
- `IDX_W`, $clog2(N*N), width of the cell index (derived, not overridden).
- `clk` input 1: system clock, rising edge.
- `resetn` input 1: reset, asynchronous, active-low.
- `start` input 1: request a scan; sampled only while idle.
- `grid` input 2*N*N: cell i = r*N+c occupies bits [2i+1:2i]; 2'd0 empty, 2'd1 player one (O), 2'd2 player two (X), 2'd3 treated as empty.
- `busy` output 1: high while a scan is in progress.
- `done` output 1: one-cycle pulse when results commit.
- `winner` output 2: 00 undetermined, 01 player one, 10 player two, 11 draw.
- `end_signal` output 1: 1 when `winner` != 00.
- `win_idx` output IDX_W: anchor cell index of the reported line; 0 when there is no win.
- `win_dir` output 2: direction from the anchor. 0 = horizontal (+c), 1 = vertical (+r), 2 = diagonal (+r,+c), 3 = anti-diagonal (+r,−c). 0 when there is no win.

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 copies `grid` into an internal snapshot, clears scan flags, sets index=0, and moves to SCAN.
  - SCAN: evaluates the snapshot cell at index each cycle. At index N*N−1, commits and moves to IDLE. Otherwise index increments.
- Per anchor cell, for each direction d in order 0,1,2,3:
  - Line valid only if all K cells lie on the board. H requires c ≤ N−K. V requires r ≤ N−K. D requires both. A requires r ≤ N−K and c ≥ K−1.
  - Line belongs to player p if all K cells equal p.
- Flags accumulated over the scan:
  - `p1_found` and `p2_found`.
  - First (lowest index, then lowest d) line location for each player.
  - `any_empty`: a cell is 2'd0 or 2'd3.
- Commit rule, in priority order:
  - `p1_found` → winner 01, using P1's first location.
  - Else `p2_found` → winner 10, using P2's first location.
  - Else no empty cells → winner 11.
  - Else → winner 00.
  - `end_signal` = (winner != 00).
- `grid` changes during SCAN have no effect; only the snapshot is scanned.
- `winner`, `end_signal`, `win_idx`, `win_dir` are registered and hold their last committed values until the next commit. They do not change during SCAN.

## Timing
- Reset values: `busy`=0, `done`=0, `winner`=00, `end_signal`=0, `win_idx`=0, `win_dir`=0. State is IDLE and the snapshot is cleared.
- `start` high at edge t (IDLE):
  - `busy`=1 after t.
  - Indices 0..N*N−1 are evaluated in cycles t..t+N*N−1.
  - Results, `done`=1 and `busy`=0 appear after edge t+N*N.
  - `done` drops after t+N*N+1.
  - Latency is fixed at N*N cycles, regardless of an early win: 9 for N=3, 25 for N=5.
- `start` while `busy`=1 is ignored; no queuing.
- `start` during the `done` cycle is accepted (state is IDLE).
- `resetn` low mid-scan aborts asynchronously. All outputs return to reset values, no `done` is issued, and the previous results are lost.

## Test plan
- N=3,K=3, empty grid, start → after 9 cycles: `done`=1, winner=00, end_signal=0, win_idx=0, win_dir=0; `busy` high for exactly 9 cycles.
- N=3, cells 0,1,2 = 1 (rest empty) → winner=01, end_signal=1, win_idx=0, win_dir=0. Also change `grid` to all-empty during the scan → result unchanged.
- N=3, cells 0,3,6 = 1 and cells 2,4,6 = 2 with cell 6 conflict replaced: cells 0,3,6 = 1; 1,4,7 = 2 → winner=01 (P1 priority), win_idx=0, win_dir=1.
- N=3, board O X O / O X X / X O O (1,2,1,1,2,2,2,1,1) → winner=11, end_signal=1, win_idx=0.
- N=5,K=4, cells 4,8,12,16 = 2 → winner=10, win_idx=4, win_dir=3, `done` 25 cycles after start.
- Robustness:
  - Second `start` at cycle 3 of a scan → ignored; a single `done`.
  - `resetn` low at cycle 5 → outputs 0 immediately, no `done`.
  - Fresh start after release → normal result.
